// File: rtl/nexys_rst_pkg.sv
// Shared types for the Nexys board reset conditioner.
package nexys_rst_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STRETCH   = 2'd2,
    RUN       = 2'd3
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_LOCK = 2'b10
  } rst_cause_e;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nexys_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// The debounced level only follows the synchronised input once it has
// differed from the current level for DEBOUNCE_CYCLES consecutive edges.
module nexys_debounce
  import nexys_rst_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 100000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             db_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous input into the clk_i domain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_p0 <= RESET_LEVEL;
      sync_p1 <= RESET_LEVEL;
    end else begin
      sync_p0 <= async_i;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a level change only after it has been stable long enough.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      db_q  <= RESET_LEVEL;
      cnt_q <= '0;
    end else if (sync_p1 == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      db_q  <= sync_p1;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign level_o = db_q;

endmodule

// File: rtl/nexys_reset_conditioner.sv
// Board-level reset conditioner for the SoC: combines the debounced
// pushbutton and the synchronised clock-lock indicator into one stretched,
// registered active-low reset, latches boot select on release, and keeps
// a record of why and how often the SoC left RUN.
module nexys_reset_conditioner
  import nexys_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int STRETCH_CYCLES  = 1024,
  parameter int COUNT_W         = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               btn_reset_ni,
  input  logic               pll_locked_i,
  input  logic               bootsel_sw_i,
  output logic               soc_rst_no,
  output logic               bootsel_o,
  output logic [1:0]         reset_cause_o,
  output logic [COUNT_W-1:0] reset_count_o
);

  localparam int                SCNT_W    = cnt_width(STRETCH_CYCLES);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STRETCH_CYCLES - 1);

  logic               btn_db;
  logic               bootsel_db;
  logic               lock_p0;
  logic               lock_p1;
  logic               ok;
  rst_state_e         state_q;
  rst_state_e         state_d;
  logic               scnt_clr;
  logic               scnt_inc;
  logic               run_enter;
  logic               run_exit;
  logic [SCNT_W-1:0]  scnt_q;
  logic               soc_rst_q;
  logic               bootsel_q;
  rst_cause_e         cause_q;
  logic [COUNT_W-1:0] count_q;

  nexys_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b1)
  ) u_btn_db (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (btn_reset_ni),
    .level_o (btn_db)
  );

  nexys_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b0)
  ) u_bootsel_db (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (bootsel_sw_i),
    .level_o (bootsel_db)
  );

  // Lock needs no debouncing, only a two-flop synchroniser.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= pll_locked_i;
      lock_p1 <= lock_p0;
    end
  end

  assign ok = lock_p1 & btn_db;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= HOLD;
    else         state_q <= state_d;
  end

  // Next-state logic and stretch-counter controls.
  always_comb begin
    state_d  = state_q;
    scnt_clr = 1'b0;
    scnt_inc = 1'b0;
    case (state_q)
      HOLD: state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (ok) begin
          state_d  = STRETCH;
          scnt_clr = 1'b1;
        end
      end
      STRETCH: begin
        if (!ok)                     state_d  = WAIT_LOCK;
        else if (scnt_q == SCNT_LAST) state_d = RUN;
        else                         scnt_inc = 1'b1;
      end
      RUN: begin
        if (!ok) state_d = WAIT_LOCK;
      end
      default: state_d = HOLD;
    endcase
  end

  assign run_enter = (state_q != RUN) && (state_d == RUN);
  assign run_exit  = (state_q == RUN) && (state_d != RUN);

  // Stretch counter: cleared on every STRETCH entry so an aborted stretch restarts in full.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)       scnt_q <= '0;
    else if (scnt_clr) scnt_q <= '0;
    else if (scnt_inc) scnt_q <= scnt_q + SCNT_W'(1);
  end

  // Registered SoC reset, boot select, last cause and saturating exit count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      soc_rst_q <= 1'b0;
      bootsel_q <= 1'b0;
      cause_q   <= CAUSE_POR;
      count_q   <= '0;
    end else begin
      soc_rst_q <= (state_d == RUN);
      if (run_enter) bootsel_q <= bootsel_db;
      if (run_exit) begin
        cause_q <= btn_db ? CAUSE_LOCK : CAUSE_BTN;
        if (count_q != {COUNT_W{1'b1}}) count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign soc_rst_no    = soc_rst_q;
  assign bootsel_o     = bootsel_q;
  assign reset_cause_o = cause_q;
  assign reset_count_o = count_q;

endmodule

// File: tb/tb_nexys_reset_conditioner.sv
// Scoreboard bench for nexys_reset_conditioner (DEBOUNCE=8, STRETCH=16, COUNT_W=8).
// Stimulus pushes expected output snapshots tagged with the clock edge after
// which they must hold; a monitor on the falling edge pops and compares them.
module tb_nexys_reset_conditioner;

  localparam int DEB = 8;
  localparam int STR = 16;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          btn_reset_ni;
  logic          pll_locked_i;
  logic          bootsel_sw_i;
  logic          soc_rst_no;
  logic          bootsel_o;
  logic [1:0]    reset_cause_o;
  logic [CW-1:0] reset_count_o;

  int edges  = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int            at;
    logic          rst_n;
    logic          bsel;
    logic [1:0]    cause;
    logic [CW-1:0] count;
    string         name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  nexys_reset_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .STRETCH_CYCLES  (STR),
    .COUNT_W         (CW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .btn_reset_ni  (btn_reset_ni),
    .pll_locked_i  (pll_locked_i),
    .bootsel_sw_i  (bootsel_sw_i),
    .soc_rst_no    (soc_rst_no),
    .bootsel_o     (bootsel_o),
    .reset_cause_o (reset_cause_o),
    .reset_count_o (reset_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic expect_at(input int at, input logic r, input logic b,
                           input logic [1:0] c, input int n, input string nm);
    exp_t e;
    e.at    = at;
    e.rst_n = r;
    e.bsel  = b;
    e.cause = c;
    e.count = CW'(n);
    e.name  = nm;
    sb.push_back(e);
  endtask

  // Called just after a falling edge: inputs assigned afterwards are sampled at edge k.
  task automatic next_is(input int k);
    while (edges + 1 < k) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at the edge just completed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= edges) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.at != edges)
        $display("FAIL %s: expectation for edge %0d missed (now edge %0d)", mon_e.name, mon_e.at, edges);
      else if (soc_rst_no !== mon_e.rst_n || bootsel_o !== mon_e.bsel ||
               reset_cause_o !== mon_e.cause || reset_count_o !== mon_e.count)
        $display("FAIL %s @edge %0d: got rst_n=%b bsel=%b cause=%b count=%0d, expected rst_n=%b bsel=%b cause=%b count=%0d",
                 mon_e.name, edges, soc_rst_no, bootsel_o, reset_cause_o, reset_count_o,
                 mon_e.rst_n, mon_e.bsel, mon_e.cause, mon_e.count);
      else
        passed++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, edges=%0d", edges);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, b0, h0, rb, l0, l1, l, guard;
    int lens [3];
    lens[0] = 3; lens[1] = 5; lens[2] = 7;

    rst_ni = 1'b0; btn_reset_ni = 1'b1; pll_locked_i = 1'b0; bootsel_sw_i = 1'b1;
    @(negedge clk);
    expect_at(3, 1'b0, 1'b0, 2'b00, 0, "reset_state");

    // Power-up: lock high from the first edge after release.
    next_is(5);
    p0 = 5;
    rst_ni = 1'b1; pll_locked_i = 1'b1;
    expect_at(p0 + 17, 1'b0, 1'b0, 2'b00, 0, "powerup_hold");
    expect_at(p0 + 18, 1'b1, 1'b1, 2'b00, 0, "powerup_release");

    // Boot select must not follow the switch while in RUN.
    next_is(p0 + 21);
    bootsel_sw_i = 1'b0;
    expect_at(p0 + 25, 1'b1, 1'b1, 2'b00, 0, "bootsel_hold_a");
    expect_at(p0 + 32, 1'b1, 1'b1, 2'b00, 0, "bootsel_hold_b");

    // Bounce: short low pulses never reset the SoC.
    next_is(p0 + 34);
    b0 = p0 + 34;
    for (int k = b0 + 1; k <= b0 + 29; k++) expect_at(k, 1'b1, 1'b1, 2'b00, 0, "bounce_hold");
    for (int i = 0; i < 3; i++) begin
      btn_reset_ni = 1'b0;
      repeat (lens[i]) @(negedge clk);
      btn_reset_ni = 1'b1;
      repeat (2) @(negedge clk);
    end

    // Sustained press.
    h0 = b0 + 21;
    btn_reset_ni = 1'b0;
    expect_at(h0 + 9,  1'b1, 1'b1, 2'b00, 0, "btn_not_yet");
    expect_at(h0 + 10, 1'b0, 1'b1, 2'b01, 1, "btn_assert");
    next_is(h0 + 12);
    rb = h0 + 12;
    btn_reset_ni = 1'b1;
    expect_at(rb + 25, 1'b0, 1'b1, 2'b01, 1, "btn_release_hold");
    expect_at(rb + 26, 1'b1, 1'b0, 2'b01, 1, "btn_release");

    // One-cycle lock loss in RUN.
    next_is(rb + 28);
    l0 = rb + 28;
    pll_locked_i = 1'b0;
    @(negedge clk);
    pll_locked_i = 1'b1;
    expect_at(l0 + 1,  1'b1, 1'b0, 2'b01, 1, "lock_not_yet");
    expect_at(l0 + 2,  1'b0, 1'b0, 2'b10, 2, "lock_assert");
    expect_at(l0 + 18, 1'b0, 1'b0, 2'b10, 2, "lock_release_hold");
    expect_at(l0 + 19, 1'b1, 1'b0, 2'b10, 2, "lock_release");

    // Lock dropped mid-stretch: full stretch re-run, count unchanged.
    next_is(l0 + 22);
    l1 = l0 + 22;
    pll_locked_i = 1'b0;
    @(negedge clk);
    pll_locked_i = 1'b1;
    expect_at(l1 + 2, 1'b0, 1'b0, 2'b10, 3, "lock_assert2");
    next_is(l1 + 12);
    pll_locked_i = 1'b0;
    @(negedge clk);
    pll_locked_i = 1'b1;
    expect_at(l1 + 19, 1'b0, 1'b0, 2'b10, 3, "stretch_abort");
    expect_at(l1 + 30, 1'b0, 1'b0, 2'b10, 3, "restretch_hold");
    expect_at(l1 + 31, 1'b1, 1'b0, 2'b10, 3, "restretch_release");

    // Drive the exit counter to 300 exits; it must stick at 255.
    next_is(l1 + 34);
    l = l1 + 34;
    for (int i = 4; i <= 300; i++) begin
      l = edges + 1;
      pll_locked_i = 1'b0;
      @(negedge clk);
      pll_locked_i = 1'b1;
      expect_at(l + 2, 1'b0, 1'b0, 2'b10, (i > 255) ? 255 : i, "sat_exit");
      next_is(l + 22);
    end
    l = edges + 1;
    expect_at(l, 1'b1, 1'b0, 2'b10, 255, "sat_run");

    // Mid-operation reset for a single edge, then a fresh power-up.
    next_is(l + 1);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    expect_at(l + 1,  1'b0, 1'b0, 2'b00, 0, "midrun_reset");
    expect_at(l + 19, 1'b0, 1'b0, 2'b00, 0, "post_reset_hold");
    expect_at(l + 20, 1'b1, 1'b0, 2'b00, 0, "post_reset_release");

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
      checks += sb.size();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
